mac_rr_arbiter: RTL and testbench

- Shares one pipelined multiply-add datapath (out = A*B + C, fixed latency) among NREQ requesters.
- Each requester presents operands with a valid/ready handshake. The arbiter grants one requester per cycle in round-robin order and drives registered operands into the datapath.
- It carries a requester tag down a delay line matched to the datapath latency, then returns the result with the originating requester's ID.
- Sits between the client blocks and the multiply-add unit. Clients never connect to the datapath directly.

---
 rtl/mac_rr_arbiter_if.sv | 36 +++
 rtl/mac_rr_arbiter.sv | 112 +++++++++++
 tb/tb_mac_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rr_arbiter_if.sv
// Bundle of the requester handshake, datapath operand/result bus and the
// result/status outputs shared between the arbiter and its environment.
interface mac_rr_arbiter_if #(
  parameter int SIZE    = 8,
  parameter int OUTSIZE = 16,
  parameter int NREQ    = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_mask;
  logic [NREQ*SIZE-1:0] req_a;
  logic [NREQ*SIZE-1:0] req_b;
  logic [NREQ*SIZE-1:0] req_c;
  logic [SIZE-1:0]      mac_a;
  logic [SIZE-1:0]      mac_b;
  logic [SIZE-1:0]      mac_c;
  logic [OUTSIZE-1:0]   mac_data;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [OUTSIZE-1:0]   res_data;
  logic                 busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_mask, req_a, req_b, req_c, mac_data,
    output req_ready, mac_a, mac_b, mac_c, res_valid, res_id, res_data, busy
  );

  // Clients plus datapath side
  modport master (
    output req_valid, req_mask, req_a, req_b, req_c, mac_data,
    input  req_ready, mac_a, mac_b, mac_c, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter that shares one fixed-latency multiply-add datapath
// among NREQ requesters. A tag delay line matched to the datapath latency
// lets each result be returned with the id of the requester that issued it.
module mac_rr_arbiter #(
  parameter int SIZE    = 8,
  parameter int OUTSIZE = 16,
  parameter int NREQ    = 4,
  parameter int LAT     = 2
) (
  input logic            clc,
  input logic            rst,
  mac_rr_arbiter_if.slave bus
);
  localparam int             IDW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    readyVec;
  logic               found;
  logic               accept;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [SIZE-1:0]    macA_q, macA_d;
  logic [SIZE-1:0]    macB_q, macB_d;
  logic [SIZE-1:0]    macC_q, macC_d;
  logic [LAT:0]       tagValid_q;
  logic [IDW-1:0]     tagId_q [LAT+1];
  logic               resValid_q;
  logic [IDW-1:0]     resId_q;
  logic [OUTSIZE-1:0] resData_q;
  logic               busy_q, busy_d;

  // Walk the requesters starting just after the last winner, wrapping once; first eligible one wins
  always_comb begin
    elig   = bus.req_valid & bus.req_mask;
    found  = 1'b0;
    winner = '0;
    cand   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant is suppressed while reset is held so no client sees a ready it cannot use
  always_comb begin
    accept   = found & rst;
    readyVec = '0;
    if (accept) readyVec[winner] = 1'b1;
  end

  // Operands and pointer move only on an accept; busy looks at the accept plus every live tag
  always_comb begin
    ptr_d  = ptr_q;
    macA_d = macA_q;
    macB_d = macB_q;
    macC_d = macC_q;
    if (accept) begin
      ptr_d  = winner;
      macA_d = bus.req_a[winner*SIZE +: SIZE];
      macB_d = bus.req_b[winner*SIZE +: SIZE];
      macC_d = bus.req_c[winner*SIZE +: SIZE];
    end
    busy_d = accept | (|tagValid_q);
  end

  // State registers, tag delay line and result capture; reset drops everything in flight
  always_ff @(posedge clc or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      macA_q     <= '0;
      macB_q     <= '0;
      macC_q     <= '0;
      tagValid_q <= '0;
      for (int i = 0; i <= LAT; i++) tagId_q[i] <= '0;
      resValid_q <= 1'b0;
      resId_q    <= '0;
      resData_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      macA_q        <= macA_d;
      macB_q        <= macB_d;
      macC_q        <= macC_d;
      tagValid_q[0] <= accept;
      tagId_q[0]    <= winner;
      for (int i = 1; i <= LAT; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagId_q[i]    <= tagId_q[i-1];
      end
      resValid_q <= tagValid_q[LAT];
      if (tagValid_q[LAT]) begin
        resId_q   <= tagId_q[LAT];
        resData_q <= bus.mac_data;
      end
      busy_q <= busy_d;
    end
  end

  assign bus.req_ready = readyVec;
  assign bus.mac_a     = macA_q;
  assign bus.mac_b     = macB_q;
  assign bus.mac_c     = macC_q;
  assign bus.res_valid = resValid_q;
  assign bus.res_id    = resId_q;
  assign bus.res_data  = resData_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Bench for mac_rr_arbiter: a two-stage multiply-add datapath model, a
// transaction-level reference of the arbiter, directed scenarios with
// hand-computed expectations, then a long randomized run.
module tb_mac_rr_arbiter;
  localparam int SIZE    = 8;
  localparam int OUTSIZE = 16;
  localparam int NREQ    = 4;
  localparam int LAT     = 2;
  localparam int IDW     = $clog2(NREQ);

  typedef struct {
    int id;
    int data;
    int due;
  } op_t;

  logic clc = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   edgeCnt    = 0;

  mac_rr_arbiter_if #(.SIZE(SIZE), .OUTSIZE(OUTSIZE), .NREQ(NREQ)) ifc ();

  mac_rr_arbiter #(.SIZE(SIZE), .OUTSIZE(OUTSIZE), .NREQ(NREQ), .LAT(LAT)) dut (
    .clc (clc),
    .rst (rst),
    .bus (ifc)
  );

  // Free-running clock
  always #5 clc = ~clc;

  // Edge counter used to measure result latency
  always @(posedge clc) edgeCnt <= edgeCnt + 1;

  // Pipelined multiply-add with LAT register stages, sharing the reset
  logic [OUTSIZE-1:0] dp [LAT];
  always @(posedge clc or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) dp[i] <= '0;
    end else begin
      dp[0] <= OUTSIZE'(ifc.mac_a) * OUTSIZE'(ifc.mac_b) + OUTSIZE'(ifc.mac_c);
      for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
    end
  end
  assign ifc.mac_data = dp[LAT-1];

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] m);
    ifc.req_valid = v;
    ifc.req_mask  = m;
  endtask

  task automatic setOps(input int i, input int a, input int b, input int c);
    ifc.req_a[i*SIZE +: SIZE] = SIZE'(a);
    ifc.req_b[i*SIZE +: SIZE] = SIZE'(b);
    ifc.req_c[i*SIZE +: SIZE] = SIZE'(c);
  endtask

  task automatic nextCycle();
    @(posedge clc);
    #2;
  endtask

  // Results seen on the DUT, for the directed scenarios
  int resIdQ[$];
  int resDataQ[$];
  int resEdgeQ[$];

  task automatic clearResults();
    resIdQ.delete();
    resDataQ.delete();
    resEdgeQ.delete();
  endtask

  initial begin : collectProc
    forever begin
      @(negedge clc);
      if (rst && ifc.res_valid) begin
        resIdQ.push_back(int'(ifc.res_id));
        resDataQ.push_back(int'(ifc.res_data));
        resEdgeQ.push_back(edgeCnt);
      end
    end
  end

  // Round-robin rule: first eligible requester after ptr, wrapping
  function automatic int arbWinner(input int ptr, input logic [NREQ-1:0] elig);
    for (int k = 1; k <= NREQ; k++) begin
      if (elig[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Reference model: compares the cycle just ended, then predicts the next edge
  initial begin : compareProc
    int                 mPtr;
    int                 mEdge;
    int                 lastAcc;
    int                 w;
    int                 d;
    logic [SIZE-1:0]    mA, mB, mC;
    logic               mRv, mBusy;
    logic [IDW-1:0]     mId;
    logic [OUTSIZE-1:0] mData;
    logic [NREQ-1:0]    expReady;
    op_t                pendQ[$];
    mPtr = 0; mEdge = 0; lastAcc = -1000;
    mA = '0; mB = '0; mC = '0; mRv = 1'b0; mBusy = 1'b0; mId = '0; mData = '0;
    forever begin
      @(negedge clc);
      if (!rst) begin
        mPtr = 0; lastAcc = -1000;
        mA = '0; mB = '0; mC = '0; mRv = 1'b0; mBusy = 1'b0; mId = '0; mData = '0;
        pendQ.delete();
      end
      checkOutput("mac_a", ifc.mac_a, mA);
      checkOutput("mac_b", ifc.mac_b, mB);
      checkOutput("mac_c", ifc.mac_c, mC);
      checkOutput("res_valid", ifc.res_valid, mRv);
      checkOutput("res_id", ifc.res_id, mId);
      checkOutput("res_data", ifc.res_data, mData);
      checkOutput("busy", ifc.busy, mBusy);
      w = rst ? arbWinner(mPtr, ifc.req_valid & ifc.req_mask) : -1;
      expReady = (w >= 0) ? (NREQ'(1) << w) : '0;
      checkOutput("req_ready", ifc.req_ready, expReady);
      if (rst) begin
        mEdge++;
        if (w >= 0) begin
          mA = ifc.req_a[w*SIZE +: SIZE];
          mB = ifc.req_b[w*SIZE +: SIZE];
          mC = ifc.req_c[w*SIZE +: SIZE];
          d  = int'(mA) * int'(mB) + int'(mC);
          mPtr = w;
          pendQ.push_back('{id: w, data: d, due: mEdge + LAT + 1});
          lastAcc = mEdge;
        end
        mBusy = (lastAcc >= mEdge - LAT - 1);
        if (pendQ.size() > 0 && pendQ[0].due == mEdge) begin
          mRv   = 1'b1;
          mId   = IDW'(pendQ[0].id);
          mData = OUTSIZE'(pendQ[0].data);
          void'(pendQ.pop_front());
        end else begin
          mRv = 1'b0;
        end
      end
    end
  end

  logic [NREQ-1:0] contReady [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int              contIds   [5] = '{1, 2, 3, 0, 1};
  int              b2bData   [5] = '{3, 5, 7, 9, 11};
  logic [NREQ-1:0] maskReady [5] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b1000};
  int              maskIds   [5] = '{1, 3, 1, 3, 3};

  // Directed scenarios followed by randomized traffic
  initial begin : mainProc
    int acceptEdge;
    ifc.req_a = '0;
    ifc.req_b = '0;
    ifc.req_c = '0;
    rst = 1'b0;
    applyStimulus('1, '1);
    for (int i = 0; i < NREQ; i++) setOps(i, i + 1, 2, 0);
    repeat (3) @(negedge clc);
    checkOutput("rstReady", ifc.req_ready, 0);
    checkOutput("rstMacA", ifc.mac_a, 0);
    checkOutput("rstResValid", ifc.res_valid, 0);
    checkOutput("rstResData", ifc.res_data, 0);
    checkOutput("rstBusy", ifc.busy, 0);

    nextCycle();
    rst = 1'b1;
    clearResults();
    @(negedge clc);
    checkOutput("firstGrant", ifc.req_ready, contReady[0]);
    for (int i = 1; i < 5; i++) begin
      nextCycle();
      @(negedge clc);
      checkOutput("contGrant", ifc.req_ready, contReady[i]);
    end
    nextCycle();
    applyStimulus('0, '1);
    repeat (8) nextCycle();
    checkOutput("contCount", resIdQ.size(), 5);
    for (int i = 0; i < 5 && i < resIdQ.size(); i++) checkOutput("contId", resIdQ[i], contIds[i]);

    clearResults();
    setOps(2, 3, 5, 7);
    applyStimulus(4'b0100, '1);
    @(negedge clc);
    checkOutput("singleGrant", ifc.req_ready, 4'b0100);
    nextCycle();
    acceptEdge = edgeCnt;
    applyStimulus('0, '1);
    repeat (8) nextCycle();
    checkOutput("singleCount", resIdQ.size(), 1);
    if (resIdQ.size() > 0) begin
      checkOutput("singleId", resIdQ[0], 2);
      checkOutput("singleData", resDataQ[0], 22);
      checkOutput("singleLatency", resEdgeQ[0] - acceptEdge, 3);
    end

    clearResults();
    for (int i = 1; i <= 5; i++) begin
      setOps(0, i, 2, 1);
      applyStimulus(4'b0001, '1);
      @(negedge clc);
      checkOutput("b2bGrant", ifc.req_ready, 4'b0001);
      nextCycle();
    end
    applyStimulus('0, '1);
    repeat (8) nextCycle();
    checkOutput("b2bCount", resDataQ.size(), 5);
    for (int i = 0; i < 5 && i < resDataQ.size(); i++) begin
      checkOutput("b2bData", resDataQ[i], b2bData[i]);
      checkOutput("b2bSpacing", resEdgeQ[i] - resEdgeQ[0], i);
    end

    clearResults();
    for (int i = 0; i < NREQ; i++) setOps(i, i + 3, i + 1, i);
    for (int i = 0; i < 5; i++) begin
      applyStimulus('1, (i < 3) ? 4'b1010 : 4'b1000);
      @(negedge clc);
      checkOutput("maskGrant", ifc.req_ready, maskReady[i]);
      nextCycle();
    end
    applyStimulus('0, '1);
    repeat (8) nextCycle();
    checkOutput("maskCount", resIdQ.size(), 5);
    for (int i = 0; i < 5 && i < resIdQ.size(); i++) checkOutput("maskId", resIdQ[i], maskIds[i]);

    clearResults();
    applyStimulus('1, '1);
    @(negedge clc);
    nextCycle();
    @(negedge clc);
    nextCycle();
    applyStimulus('0, '1);
    nextCycle();
    rst = 1'b0;
    @(negedge clc);
    checkOutput("midRstValid", ifc.res_valid, 0);
    checkOutput("midRstBusy", ifc.busy, 0);
    nextCycle();
    @(negedge clc);
    checkOutput("midRstValid2", ifc.res_valid, 0);
    nextCycle();
    rst = 1'b1;
    applyStimulus('1, '1);
    @(negedge clc);
    checkOutput("postRstGrant", ifc.req_ready, 4'b0010);
    checkOutput("postRstBusy", ifc.busy, 0);
    nextCycle();
    applyStimulus('0, '1);
    repeat (8) nextCycle();
    checkOutput("postRstCount", resIdQ.size(), 1);
    if (resIdQ.size() > 0) checkOutput("postRstId", resIdQ[0], 1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++)
        setOps(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      applyStimulus(NREQ'($urandom), ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '1);
      rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      nextCycle();
    end
    rst = 1'b1;
    applyStimulus('0, '1);
    repeat (10) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
